// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared defaults and constants for the multi-port register
//                file and its write arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package rf_pkg;
    localparam int          RF_DATA_W   = 32;
    localparam int          RF_ADDR_W   = 5;
    localparam int          RF_REG_ZERO = 0;      // hard-wired zero register
    localparam int          RF_INIT_IDX = 16;
    localparam logic [31:0] RF_INIT_VAL = 32'h17;
endpackage
`default_nettype wire

// File: rtl/rf_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wr_arb
//  Description : Per-address write resolver. Reports whether any enabled
//                write port targets i_q_addr and returns the data of the
//                highest-indexed such port.
//  Revision    : 1.0  initial release
// ============================================================================
module rf_wr_arb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NWR    = 2
) (
    input  logic [ADDR_W-1:0]     i_q_addr,
    input  logic [NWR-1:0]        i_we,
    input  logic [NWR*ADDR_W-1:0] i_wr_addr,
    input  logic [NWR*DATA_W-1:0] i_wr_data,
    output logic                  o_hit,
    output logic [DATA_W-1:0]     o_data
);

    // Scan ports low to high so the last (highest) matching port overwrites.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int j = 0; j < NWR; j++) begin
            if (i_we[j] && (i_wr_addr[j*ADDR_W +: ADDR_W] == i_q_addr)) begin
                o_hit  = 1'b1;
                o_data = i_wr_data[j*DATA_W +: DATA_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rf_mp.sv
`default_nettype none
// ============================================================================
//  Module      : rf_mp
//  Description : Flop-based multi-port register file with a zero register,
//                optional write-to-read forwarding and a per-register busy
//                scoreboard reported alongside each registered read.
//  Revision    : 1.0  initial release
// ============================================================================
module rf_mp
    import rf_pkg::*;
#(
    parameter int                DATA_W   = RF_DATA_W,
    parameter int                ADDR_W   = RF_ADDR_W,
    parameter int                NRD      = 2,
    parameter int                NWR      = 2,
    parameter int                BYPASS   = 1,
    parameter int                INIT_IDX = RF_INIT_IDX,
    parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(RF_INIT_VAL)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR-1:0]        we,
    input  logic [NWR*ADDR_W-1:0] wr_addr,
    input  logic [NWR*DATA_W-1:0] wr_data,
    input  logic                  busy_set,
    input  logic [ADDR_W-1:0]     busy_addr,
    input  logic [ADDR_W-1:0]     dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] w_regs  [DEPTH];   // current stored contents
    logic [DATA_W-1:0] w_wdata [DEPTH];   // winning write data per address
    logic [DEPTH-1:0]  w_hit;             // address is written this cycle
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_nxt;

    // One arbiter and one storage word per address; register 0 has neither.
    for (genvar a = 0; a < DEPTH; a++) begin : g_reg
        if (a == RF_REG_ZERO) begin : g_zero
            assign w_regs[a]  = '0;
            assign w_wdata[a] = '0;
            assign w_hit[a]   = 1'b0;
        end else begin : g_store
            logic [DATA_W-1:0] r_q;

            rf_wr_arb #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W),
                .NWR    (NWR)
            ) u_arb (
                .i_q_addr  (ADDR_W'(a)),
                .i_we      (we),
                .i_wr_addr (wr_addr),
                .i_wr_data (wr_data),
                .o_hit     (w_hit[a]),
                .o_data    (w_wdata[a])
            );

            // Storage word: reset to its init value, else take the winning write.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q <= (a == INIT_IDX) ? INIT_VAL : '0;
                end else if (w_hit[a]) begin
                    r_q <= w_wdata[a];
                end
            end

            assign w_regs[a] = r_q;
        end
    end

    // Next busy state: writes clear, a new producer set wins over a clear.
    always_comb begin
        w_busy_nxt = r_busy & ~w_hit;
        if (busy_set) begin
            w_busy_nxt[busy_addr] = 1'b1;
        end
        w_busy_nxt[RF_REG_ZERO] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Read ports: optional forwarding of this cycle's write, then register.
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd_nxt;
        logic              w_rb_nxt;
        logic [DATA_W-1:0] r_rd_q;
        logic              r_rb_q;

        assign w_ra     = rd_addr[i*ADDR_W +: ADDR_W];
        assign w_rd_nxt = ((BYPASS != 0) && w_hit[w_ra]) ? w_wdata[w_ra] : w_regs[w_ra];
        assign w_rb_nxt = (BYPASS != 0) ? w_busy_nxt[w_ra] : r_busy[w_ra];

        // Read data and busy flag travel together through one register stage.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_rd_q <= '0;
                r_rb_q <= 1'b0;
            end else begin
                r_rd_q <= w_rd_nxt;
                r_rb_q <= w_rb_nxt;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = r_rd_q;
        assign rd_busy[i]                  = r_rb_q;
    end

    assign dbg_data = w_regs[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_rf_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_mp
//  Description : Self-checking bench for rf_mp. Drives a forwarding (BYPASS=1)
//                and a non-forwarding (BYPASS=0) instance with identical
//                stimulus: a directed vector table, a short hand sequence and
//                randomized traffic checked against a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rf_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [1:0]  we;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        busy_set;
    logic [4:0]  busy_addr;
    logic [4:0]  dbg_addr;

    logic [63:0] rd_data_b1, rd_data_b0;
    logic [1:0]  rd_busy_b1, rd_busy_b0;
    logic [31:0] dbg_b1, dbg_b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rf_mp u_dut1 (
        .clk (clk), .rst (rst), .rd_addr (rd_addr), .rd_data (rd_data_b1),
        .rd_busy (rd_busy_b1), .we (we), .wr_addr (wr_addr), .wr_data (wr_data),
        .busy_set (busy_set), .busy_addr (busy_addr), .dbg_addr (dbg_addr),
        .dbg_data (dbg_b1)
    );

    rf_mp #(.BYPASS(0)) u_dut0 (
        .clk (clk), .rst (rst), .rd_addr (rd_addr), .rd_data (rd_data_b0),
        .rd_busy (rd_busy_b0), .we (we), .wr_addr (wr_addr), .wr_data (wr_data),
        .busy_set (busy_set), .busy_addr (busy_addr), .dbg_addr (dbg_addr),
        .dbg_data (dbg_b0)
    );

    // Reference model: architectural contents and scoreboard.
    logic [31:0] m_mem [32];
    logic [31:0] m_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 32; k++) m_mem[k] = 32'h0;
        m_mem[16] = 32'h17;
        m_busy    = 32'h0;
    endtask

    // One clock: check dbg, predict outputs, clock, compare both instances.
    task automatic cycle();
        logic [31:0] nmem [32];
        logic [31:0] nbusy;
        logic [31:0] e1 [2];
        logic [31:0] e0 [2];
        logic [1:0]  b1, b0;
        logic [4:0]  a;
        #1;
        chk("dbg_b1", dbg_b1, m_mem[dbg_addr]);
        chk("dbg_b0", dbg_b0, m_mem[dbg_addr]);
        nmem  = m_mem;
        nbusy = m_busy;
        if (rst) begin
            for (int k = 0; k < 32; k++) nmem[k] = 32'h0;
            nmem[16] = 32'h17;
            nbusy    = 32'h0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                a = wr_addr[j*5 +: 5];
                if (we[j] && a != 5'd0) begin
                    nmem[a]  = wr_data[j*32 +: 32];
                    nbusy[a] = 1'b0;
                end
            end
            if (busy_set && busy_addr != 5'd0) nbusy[busy_addr] = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            a = rd_addr[i*5 +: 5];
            e1[i] = rst ? 32'h0 : nmem[a];
            e0[i] = rst ? 32'h0 : m_mem[a];
            b1[i] = rst ? 1'b0 : nbusy[a];
            b0[i] = rst ? 1'b0 : m_busy[a];
        end
        @(posedge clk);
        m_mem  = nmem;
        m_busy = nbusy;
        #1;
        chk("rd0_b1", rd_data_b1[31:0],  e1[0]);
        chk("rd1_b1", rd_data_b1[63:32], e1[1]);
        chk("rd0_b0", rd_data_b0[31:0],  e0[0]);
        chk("rd1_b0", rd_data_b0[63:32], e0[1]);
        chk("busy_b1", {30'd0, rd_busy_b1}, {30'd0, b1});
        chk("busy_b0", {30'd0, rd_busy_b0}, {30'd0, b0});
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        bs;
        logic [4:0]  ba;
        logic [4:0]  ra0, ra1;
        logic [31:0] exp0, exp1;   // BYPASS=1 read data after the edge
        logic [1:0]  expb;         // BYPASS=1 rd_busy after the edge
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [1:0] w,
                                input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic bs, input logic [4:0] ba,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [1:0] eb);
        vec_t v;
        v.rst = r; v.we = w; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.bs = bs; v.ba = ba; v.ra0 = ra0; v.ra1 = ra1;
        v.exp0 = e0; v.exp1 = e1; v.expb = eb;
        return v;
    endfunction

    task automatic drive(input logic r, input logic [1:0] w,
                         input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic [4:0] wa1, input logic [31:0] wd1,
                         input logic bs, input logic [4:0] ba,
                         input logic [4:0] ra0, input logic [4:0] ra1,
                         input logic [4:0] da);
        rst = r; we = w;
        wr_addr = {wa1, wa0}; wr_data = {wd1, wd0};
        busy_set = bs; busy_addr = ba;
        rd_addr = {ra1, ra0}; dbg_addr = da;
    endtask

    vec_t tbl [14];

    initial begin
        //          rst we    wa0 wd0          wa1 wd1       bs ba  ra0 ra1 exp0         exp1      expb
        tbl[0]  = mk(1, 2'b00, 0, 0,           0,  0,        0, 0,  16, 5,  0,           0,        2'b00);
        tbl[1]  = mk(0, 2'b00, 0, 0,           0,  0,        0, 0,  16, 5,  32'h17,      0,        2'b00);
        tbl[2]  = mk(0, 2'b11, 7, 32'h55,      7,  32'hAA,   0, 0,  7,  16, 32'hAA,      32'h17,   2'b00);
        tbl[3]  = mk(0, 2'b00, 0, 0,           0,  0,        0, 0,  7,  7,  32'hAA,      32'hAA,   2'b00);
        tbl[4]  = mk(0, 2'b01, 3, 32'hDEAD,    0,  0,        0, 0,  3,  7,  32'hDEAD,    32'hAA,   2'b00);
        tbl[5]  = mk(0, 2'b00, 0, 0,           0,  0,        0, 0,  3,  0,  32'hDEAD,    0,        2'b00);
        tbl[6]  = mk(0, 2'b01, 0, 32'hFFFF,    0,  0,        1, 0,  0,  0,  0,           0,        2'b00);
        tbl[7]  = mk(0, 2'b00, 0, 0,           0,  0,        1, 9,  9,  0,  0,           0,        2'b01);
        tbl[8]  = mk(0, 2'b10, 0, 0,           9,  32'h99,   1, 9,  9,  9,  32'h99,      32'h99,   2'b11);
        tbl[9]  = mk(0, 2'b01, 9, 32'h77,      0,  0,        0, 0,  9,  16, 32'h77,      32'h17,   2'b00);
        tbl[10] = mk(0, 2'b00, 0, 0,           0,  0,        0, 0,  9,  9,  32'h77,      32'h77,   2'b00);
        tbl[11] = mk(1, 2'b01, 4, 32'h1234,    0,  0,        1, 4,  4,  16, 0,           0,        2'b00);
        tbl[12] = mk(0, 2'b00, 0, 0,           0,  0,        0, 0,  4,  16, 0,           32'h17,   2'b00);
        tbl[13] = mk(0, 2'b11, 12, 32'h1,      12, 32'h2,    0, 0,  12, 12, 32'h2,       32'h2,    2'b00);

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();

        // Directed vectors.
        for (int t = 0; t < 14; t++) begin
            drive(tbl[t].rst, tbl[t].we, tbl[t].wa0, tbl[t].wd0, tbl[t].wa1, tbl[t].wd1,
                  tbl[t].bs, tbl[t].ba, tbl[t].ra0, tbl[t].ra1, tbl[t].ra0);
            cycle();
            chk($sformatf("tbl%0d_rd0", t), rd_data_b1[31:0],  tbl[t].exp0);
            chk($sformatf("tbl%0d_rd1", t), rd_data_b1[63:32], tbl[t].exp1);
            chk($sformatf("tbl%0d_busy", t), {30'd0, rd_busy_b1}, {30'd0, tbl[t].expb});
        end

        // Forwarding contrast: BYPASS=0 sees old contents first, new one cycle later.
        drive(0, 2'b01, 3, 32'hBEEF, 0, 0, 0, 0, 3, 3, 3);
        cycle();
        chk("seq_fwd_b1", rd_data_b1[31:0], 32'hBEEF);
        chk("seq_old_b0", rd_data_b0[31:0], 32'h0);
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 3, 3);
        cycle();
        chk("seq_new_b0", rd_data_b0[31:0], 32'hBEEF);
        chk("seq_dbg",    dbg_b0,           32'hBEEF);

        // Randomized traffic on a narrow address window to provoke collisions.
        for (int n = 0; n < 600; n++) begin
            logic [4:0] ad [6];
            for (int k = 0; k < 6; k++)
                ad[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                    : 5'($urandom_range(0, 6));
            drive(($urandom_range(0, 49) == 0), 2'($urandom), ad[0], $urandom,
                  ad[1], $urandom, 1'($urandom), ad[2], ad[3], ad[4], ad[5]);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
